// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// The fetch stage drives the request and address; memory answers with ready/data.
interface fetch_stage_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (output imemReq, output imemAddr, input imemReady, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemReady, output imemData);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: computes nextPc, requests instruction memory and
// owns the IF/ID pipeline register with stall holding, redirect and flushing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [31:0]        branchTarget,
  input  logic               jump,
  input  logic [31:0]        jumpTarget,
  fetch_stage_if.master      imem,
  output logic [31:0]        nextPc,
  output logic [31:0]        instrOut,
  output logic [31:0]        pcPlus4Out,
  output logic               validOut,
  output logic [COUNT_W-1:0] fetchCount
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        hold_buf_q, hold_buf_d;
  logic [31:0]        hold_pc4_q, hold_pc4_d;
  logic [31:0]        next_pc;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // The older instruction (the branch) wins when both redirects fire.
  assign redirect        = branchTaken | jump;
  assign redirect_target = branchTaken ? branchTarget : jumpTarget;
  assign pc_plus4        = pc + 32'd4;

  // Next-state and nextPc selection: reset > redirect > delivery/stall.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    hold_buf_d = hold_buf_q;
    hold_pc4_d = hold_pc4_q;
    next_pc    = pc;

    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      // Flush IF/ID, drop any parked instruction and same-cycle memory data.
      next_pc    = redirect_target;
      valid_d    = 1'b0;
      instr_d    = 32'd0;
      hold_buf_d = 32'd0;
      hold_pc4_d = 32'd0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imemReady && !stall) begin
            instr_d = imem.imemData;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + COUNT_W'(1);
            next_pc = pc_plus4;
          end else if (imem.imemReady) begin
            // Decode is stalled: park the word so memory is not asked again.
            hold_buf_d = imem.imemData;
            hold_pc4_d = pc_plus4;
            state_d    = HOLD;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = hold_buf_q;
            pc4_d   = hold_pc4_q;
            valid_d = 1'b1;
            count_d = count_q + COUNT_W'(1);
            next_pc = hold_pc4_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, IF/ID register, hold buffer and counter update on the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= FETCH;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      // NOTE: the hold buffer is a plain register pair, not a memory array, so
      // clearing it on reset is cheap and keeps post-reset state deterministic.
      hold_buf_q <= 32'd0;
      hold_pc4_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      hold_buf_q <= hold_buf_d;
      hold_pc4_q <= hold_pc4_d;
    end
  end

  assign nextPc        = next_pc;
  assign imem.imemReq  = !reset && (state_q == FETCH);
  assign imem.imemAddr = pc;
  assign instrOut      = instr_q;
  assign pcPlus4Out    = pc4_q;
  assign validOut      = valid_q;
  assign fetchCount    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (counter narrowed to 4 bits so
// the wrap is reachable). Inputs change on the falling edge like the PC
// register; combinational outputs are checked before the rising edge and
// registered outputs just after it.
module tb_fetch_stage;

  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        pc;
  logic               stall;
  logic               branchTaken;
  logic [31:0]        branchTarget;
  logic               jump;
  logic [31:0]        jumpTarget;
  logic [31:0]        nextPc;
  logic [31:0]        instrOut;
  logic [31:0]        pcPlus4Out;
  logic               validOut;
  logic [COUNT_W-1:0] fetchCount;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .imem         (imem.master),
    .nextPc       (nextPc),
    .instrOut     (instrOut),
    .pcPlus4Out   (pcPlus4Out),
    .validOut     (validOut),
    .fetchCount   (fetchCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        rdy;
    logic [31:0] data;
    logic [31:0] e_npc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [3:0]  e_cnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset             = v.rst;
    pc                = v.pc;
    stall             = v.stall;
    branchTaken       = v.br;
    branchTarget      = v.brt;
    jump              = v.jmp;
    jumpTarget        = v.jmpt;
    imem.imemReady    = v.rdy;
    imem.imemData     = v.data;
  endtask

  // One cycle: apply at falling edge, check comb outputs, check regs after the edge.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d nextPc", idx), nextPc, v.e_npc);
    check($sformatf("v%0d imemReq", idx), {31'd0, imem.imemReq}, {31'd0, v.e_req});
    check($sformatf("v%0d imemAddr", idx), imem.imemAddr, v.pc);
    @(posedge clk);
    #1;
    check($sformatf("v%0d validOut", idx), {31'd0, validOut}, {31'd0, v.e_valid});
    check($sformatf("v%0d instrOut", idx), instrOut, v.e_instr);
    check($sformatf("v%0d pcPlus4Out", idx), pcPlus4Out, v.e_pc4);
    check($sformatf("v%0d fetchCount", idx), {28'd0, fetchCount}, {28'd0, v.e_cnt});
  endtask

  vec_t vecs[21];

  initial begin
    vec_t v;
    //          rst pc            st br brt        jmp jmpt       rdy data          | npc          req val instr         pc4           cnt
    vecs[0]  = '{1, 32'h40,       0, 0, 32'h0,     0, 32'h0,     1, 32'h99,       32'h0,        0, 0, 32'h0,        32'h0,        0}; // reset
    vecs[1]  = '{1, 32'h40,       0, 0, 32'h0,     0, 32'h0,     1, 32'h99,       32'h0,        0, 0, 32'h0,        32'h0,        0};
    vecs[2]  = '{0, 32'h0,        0, 0, 32'h0,     0, 32'h0,     1, 32'h11,       32'h4,        1, 1, 32'h11,       32'h4,        1}; // streaming
    vecs[3]  = '{0, 32'h4,        0, 0, 32'h0,     0, 32'h0,     1, 32'h22,       32'h8,        1, 1, 32'h22,       32'h8,        2};
    vecs[4]  = '{0, 32'h8,        0, 0, 32'h0,     0, 32'h0,     1, 32'h33,       32'hC,        1, 1, 32'h33,       32'hC,        3};
    vecs[5]  = '{0, 32'hC,        0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'hC,        1, 0, 32'h33,       32'hC,        3}; // memory wait
    vecs[6]  = '{0, 32'hC,        0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'hC,        1, 0, 32'h33,       32'hC,        3};
    vecs[7]  = '{0, 32'h100,      1, 0, 32'h0,     0, 32'h0,     1, 32'hAA,       32'h100,      1, 0, 32'h33,       32'hC,        3}; // stall -> HOLD
    vecs[8]  = '{0, 32'h100,      1, 0, 32'h0,     0, 32'h0,     1, 32'hBB,       32'h100,      0, 0, 32'h33,       32'hC,        3};
    vecs[9]  = '{0, 32'h100,      1, 0, 32'h0,     0, 32'h0,     1, 32'hBB,       32'h100,      0, 0, 32'h33,       32'hC,        3};
    vecs[10] = '{0, 32'h100,      0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h104,      0, 1, 32'hAA,       32'h104,      4}; // release
    vecs[11] = '{0, 32'h104,      0, 0, 32'h0,     0, 32'h0,     1, 32'h55,       32'h108,      1, 1, 32'h55,       32'h108,      5};
    vecs[12] = '{0, 32'h108,      1, 0, 32'h0,     0, 32'h0,     1, 32'hCC,       32'h108,      1, 1, 32'h55,       32'h108,      5}; // park CC
    vecs[13] = '{0, 32'h108,      1, 1, 32'h200,   1, 32'h300,   1, 32'hDD,       32'h200,      0, 0, 32'h0,        32'h108,      5}; // br+jmp+stall in HOLD
    vecs[14] = '{0, 32'h200,      0, 0, 32'h0,     0, 32'h0,     1, 32'hEE,       32'h204,      1, 1, 32'hEE,       32'h204,      6}; // FETCH, CC lost
    vecs[15] = '{0, 32'h204,      0, 0, 32'h0,     1, 32'h300,   1, 32'h77,       32'h300,      1, 0, 32'h0,        32'h204,      6}; // jump only
    vecs[16] = '{0, 32'hFFFF_FFFC,0, 0, 32'h0,     0, 32'h0,     1, 32'h1234_5678,32'h0,        1, 1, 32'h1234_5678,32'h0,        7}; // pc+4 wrap
    vecs[17] = '{0, 32'h0,        1, 0, 32'h0,     0, 32'h0,     1, 32'h66,       32'h0,        1, 1, 32'h1234_5678,32'h0,        7}; // enter HOLD
    vecs[18] = '{1, 32'h0,        1, 0, 32'h0,     0, 32'h0,     1, 32'h66,       32'h0,        0, 0, 32'h0,        32'h0,        0}; // reset mid-HOLD
    vecs[19] = '{1, 32'h0,        0, 1, 32'h500,   0, 32'h0,     1, 32'h66,       32'h0,        0, 0, 32'h0,        32'h0,        0}; // reset beats redirect
    vecs[20] = '{0, 32'h0,        0, 0, 32'h0,     0, 32'h0,     1, 32'h42,       32'h4,        1, 1, 32'h42,       32'h4,        1};

    v = vecs[0];
    drive(v);

    for (int i = 0; i < 21; i++) begin
      run_vec(i, vecs[i]);
    end

    // Counter wrap: 15 more back-to-back deliveries take the 4-bit count 1 -> 0.
    for (int k = 0; k < 15; k++) begin
      v = '{0, 32'(4 + 4 * k), 0, 0, 32'h0, 0, 32'h0, 1, 32'(32'hA000 + k),
            32'(8 + 4 * k), 1, 1, 32'(32'hA000 + k), 32'(8 + 4 * k), 4'((k + 2) % 16)};
      run_vec(100 + k, v);
    end
    check("wrap fetchCount", {28'd0, fetchCount}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipeline. It sits between the PC register and decode:
- consumes the current `pc` and drives `nextPc` back into the PC register;
- talks to instruction memory over a req/ready handshake;
- owns the IF/ID pipeline register, including stall holding, branch/jump redirect and flushing.

## Interface
- `RESET_PC`, 32'h0000_0000, value driven on `nextPc` while reset is asserted.
- `COUNT_W`, 16, width of the delivered-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `pc`  in  32  current PC from the PC register (changes only on falling edge).
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `branchTaken`  in  1  branch resolved taken; redirect request.
- `branchTarget`  in  32  branch destination.
- `jump`  in  1  jump redirect request.
- `jumpTarget`  in  32  jump destination.
- `imemReady`  in  1  instruction memory has valid `imemData` for `imemAddr`.
- `imemData`  in  32  fetched instruction word.
- `imemReq`  out  1  fetch request.
- `imemAddr`  out  32  fetch address, equal to `pc`.
- `nextPc`  out  32  value for the PC register to load.
- `instrOut`  out  32  IF/ID instruction.
- `pcPlus4Out`  out  32  IF/ID PC+4 of `instrOut`.
- `validOut`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetchCount`  out  `COUNT_W`  instructions delivered into IF/ID; wraps modulo 2^`COUNT_W`.

## Operation
- `redirect` = `branchTaken | jump`.
- Target selection: `branchTaken` wins over `jump` (the branch is the older instruction).
- FSM states:
  - **FETCH**: `imemReq`=1.
  - **HOLD**: `imemReq`=0; the instruction is parked in an internal `holdBuf`/`holdPc4`.
- Priority per cycle: `reset` > `redirect` > delivery/stall.
- Redirect (any state):
  - `nextPc`=target.
  - IF/ID flushed: `validOut`<=0, `instrOut`<=0.
  - `holdBuf` discarded; same-cycle `imemReady` data discarded.
  - state<=FETCH.
- FETCH with `imemReady` and `!stall`:
  - `instrOut`<=`imemData`, `pcPlus4Out`<=`pc`+4, `validOut`<=1, `fetchCount`++.
  - `nextPc`=`pc`+4.
- FETCH with `imemReady` and `stall`:
  - `holdBuf`<=`imemData`, `holdPc4`<=`pc`+4.
  - IF/ID unchanged; `nextPc`=`pc`; state<=HOLD.
- FETCH with `!imemReady`:
  - `nextPc`=`pc`.
  - If `!stall`, `validOut`<=0 (bubble). If `stall`, IF/ID unchanged.
- HOLD with `stall`: everything unchanged, `nextPc`=`pc`.
- HOLD with `!stall`:
  - IF/ID<=`holdBuf`/`holdPc4`, `validOut`<=1, `fetchCount`++.
  - `nextPc`=`holdPc4`; state<=FETCH.
- Adders are 32-bit; `pc`+4 wraps 32'hFFFF_FFFC -> 0 with no carry out. Targets are used unmodified; no alignment check.

## Timing
- `nextPc`, `imemReq` and `imemAddr` are combinational from state and inputs. They are stable before the falling edge, when the PC register samples `nextPc`.
- The memory sees the new `pc` half a cycle after the PC update.
- IF/ID outputs, FSM state, hold buffer and counter update on the rising edge of `clk`.
- Latency: `imemReady` at rising edge N -> `instrOut`/`validOut` valid after edge N, if not stalled.
- Throughput is one instruction per cycle with zero-wait memory.
- Reset (synchronous; takes effect at the rising edge while `reset`=1, including mid-HOLD or mid-wait):
  - state=FETCH, `validOut`=0, `instrOut`=0, `pcPlus4Out`=0, `fetchCount`=0, hold buffer cleared.
  - While `reset`=1: `nextPc`=`RESET_PC` and `imemReq`=0.
- Simultaneous `reset` and `redirect`: reset wins.
- Simultaneous `redirect` and `stall`: redirect wins; the flush overrides the stall hold.
- `fetchCount` wraps from 2^`COUNT_W`-1 to 0.

## Test plan
- **Reset**: hold `reset` 2 cycles with `pc`=0x40.
  - Required: `nextPc`=`RESET_PC`, `imemReq`=0, `validOut`=0, `fetchCount`=0.
- **Streaming**: `imemReady`=1 every cycle, `pc` following `nextPc` from 0, data 0x11,0x22,0x33.
  - Required: `instrOut` 0x11/0x22/0x33 on consecutive cycles, `pcPlus4Out` 4/8/12, `fetchCount`=3.
- **Stall during delivery**: `pc`=0x100, `imemReady`=1, data 0xAA, `stall` high for 3 cycles.
  - Required: HOLD entered, `imemReq`=0, `nextPc`=0x100 and IF/ID unchanged for 3 cycles.
  - On stall release: `instrOut`=0xAA, `pcPlus4Out`=0x104, `nextPc`=0x104.
- **Memory wait**: `imemReady` low 2 cycles, `stall`=0.
  - Required: `validOut`=0 both cycles and `nextPc`=`pc`.
- **Redirect**: `branchTaken`=1 (target 0x200) together with `jump`=1 (0x300), `stall`=1 and HOLD occupied.
  - Required: `nextPc`=0x200, `validOut`=0 next edge, hold data never delivered, state FETCH.
- **Boundary**: `pc`=0xFFFF_FFFC delivered -> `pcPlus4Out`=0, `nextPc`=0.
  - With `COUNT_W`=4: 16 deliveries -> `fetchCount` wraps to 0.
